prog_freq_div_nch: RTL and testbench

- Multi-channel, run-time programmable integer clock divider. Next generation of the fixed-factor divider.
- Each channel divides CLK_in by a programmable factor with a programmable high time (duty cycle).
- New divide/duty values take effect glitch-free at the period boundary.
- All channels restart phase-aligned on SYNC. Serves as the clock/strobe generator for peripheral timing blocks.

---
 rtl/prog_freq_div_nch.sv | 122 ++++++++++++
 tb/tb_prog_freq_div_nch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_freq_div_nch.sv
// Multi-channel run-time programmable integer clock divider.
// Each channel divides CLK_in by a programmable factor with a programmable
// high time. New settings are held in a shadow register and become active
// only at a period boundary, so the output never shows a truncated pulse.
// All channels are held in a restart state while SYNC is low and rise
// together on the first edge after SYNC returns high.
module prog_freq_div_nch #(
  parameter int unsigned CH       = 2,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV_DEF  = 2,
  parameter int unsigned HIGH_DEF = 1
) (
  input  logic                  CLK_in,
  input  logic                  RST,
  input  logic                  SYNC,
  input  logic [CH-1:0]         LOAD,
  input  logic [CH*WIDTH-1:0]   DIV_in,
  input  logic [CH*WIDTH-1:0]   HIGH_in,
  output logic [CH-1:0]         CLK_out,
  output logic [CH-1:0]         TICK_out,
  output logic [CH-1:0]         PEND_out,
  output logic [CH-1:0]         ERR_out
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DIV_DEF);
  localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(HIGH_DEF);
  localparam logic [WIDTH-1:0] CNT_RST  = WIDTH'(DIV_DEF - 1);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_a_q, div_a_d, high_a_q, high_a_d;
    logic [WIDTH-1:0] div_s_q, div_s_d, high_s_q, high_s_d;
    logic [WIDTH-1:0] div_w, high_w;
    logic             pend_q, pend_d, err_q, err_d;
    logic             clk_q, clk_d, tick_q, tick_d;
    logic             legal, wrap;

    assign div_w  = DIV_in[g*WIDTH +: WIDTH];
    assign high_w = HIGH_in[g*WIDTH +: WIDTH];
    assign legal  = (div_w >= WIDTH'(2)) && (high_w != '0) && (high_w < div_w);
    assign wrap   = SYNC && (cnt_q == div_a_q - WIDTH'(1));

    // Next-state: shadow capture, apply at boundary or during hold, counter, outputs.
    always_comb begin
      cnt_d    = cnt_q;
      div_a_d  = div_a_q;
      high_a_d = high_a_q;
      div_s_d  = div_s_q;
      high_s_d = high_s_q;
      pend_d   = pend_q;
      err_d    = err_q;

      // While held, an already pending config goes live before this cycle's
      // LOAD is captured, so a LOAD during hold lands one edge later.
      if (!SYNC && pend_q) begin
        div_a_d  = div_s_q;
        high_a_d = high_s_q;
        pend_d   = 1'b0;
      end

      if (LOAD[g]) begin
        if (legal) begin
          div_s_d  = div_w;
          high_s_d = high_w;
          pend_d   = 1'b1;
          err_d    = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end

      // Applying from the updated shadow lets a LOAD on the wrap edge bypass.
      if (wrap && pend_d) begin
        div_a_d  = div_s_d;
        high_a_d = high_s_d;
        pend_d   = 1'b0;
      end

      if (!SYNC) begin
        cnt_d = div_a_d - WIDTH'(1);
      end else if (wrap) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end

      clk_d  = SYNC && (cnt_d < high_a_d);
      tick_d = wrap;
    end

    // Channel state register with asynchronous active-low reset.
    always_ff @(posedge CLK_in or negedge RST) begin
      if (!RST) begin
        cnt_q    <= CNT_RST;
        div_a_q  <= DIV_RST;
        high_a_q <= HIGH_RST;
        div_s_q  <= DIV_RST;
        high_s_q <= HIGH_RST;
        pend_q   <= 1'b0;
        err_q    <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_a_q  <= div_a_d;
        high_a_q <= high_a_d;
        div_s_q  <= div_s_d;
        high_s_q <= high_s_d;
        pend_q   <= pend_d;
        err_q    <= err_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign CLK_out[g]  = clk_q;
    assign TICK_out[g] = tick_q;
    assign PEND_out[g] = pend_q;
    assign ERR_out[g]  = err_q;
  end

endmodule

// File: tb/tb_prog_freq_div_nch.sv
// Directed bench for prog_freq_div_nch with a per-cycle behavioural model
// feeding a scoreboard, plus explicit waveform pattern checks.
module tb_prog_freq_div_nch;

  localparam int unsigned CH = 2;
  localparam int unsigned W  = 8;

  logic              CLK_in  = 1'b0;
  logic              RST     = 1'b0;
  logic              SYNC    = 1'b0;
  logic [CH-1:0]     LOAD    = '0;
  logic [CH*W-1:0]   DIV_in  = '0;
  logic [CH*W-1:0]   HIGH_in = '0;
  logic [CH-1:0]     CLK_out, TICK_out, PEND_out, ERR_out;

  prog_freq_div_nch #(.CH(CH), .WIDTH(W), .DIV_DEF(2), .HIGH_DEF(1)) dut (
    .CLK_in   (CLK_in),
    .RST      (RST),
    .SYNC     (SYNC),
    .LOAD     (LOAD),
    .DIV_in   (DIV_in),
    .HIGH_in  (HIGH_in),
    .CLK_out  (CLK_out),
    .TICK_out (TICK_out),
    .PEND_out (PEND_out),
    .ERR_out  (ERR_out)
  );

  always #5 CLK_in = ~CLK_in;

  typedef struct packed {
    logic [CH-1:0] clk;
    logic [CH-1:0] tick;
    logic [CH-1:0] pend;
    logic [CH-1:0] err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] hist0 = '0, hist1 = '0, thist0 = '0;

  int unsigned m_cnt[CH], m_div[CH], m_high[CH], m_sdiv[CH], m_shigh[CH];
  logic        m_pend[CH], m_err[CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] pk2(input int unsigned a0, input int unsigned a1);
    return {W'(a1), W'(a0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 1; m_div[i] = 2; m_high[i] = 1;
      m_sdiv[i] = 2; m_shigh[i] = 1; m_pend[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic sync, input logic [CH-1:0] load,
                            input logic [CH*W-1:0] div, input logic [CH*W-1:0] high);
    exp_t e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      int unsigned d, h;
      d = 32'(div[i*W +: W]);
      h = 32'(high[i*W +: W]);
      if (!sync && m_pend[i]) begin
        m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 1'b0;
      end
      if (load[i]) begin
        if (d >= 2 && h >= 1 && h < d) begin
          m_sdiv[i] = d; m_shigh[i] = h; m_pend[i] = 1'b1; m_err[i] = 1'b0;
        end else begin
          m_err[i] = 1'b1;
        end
      end
      if (sync) begin
        if (m_cnt[i] == m_div[i] - 1) begin
          if (m_pend[i]) begin
            m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 1'b0;
          end
          m_cnt[i] = 0;
          e.tick[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        e.clk[i] = (m_cnt[i] < m_high[i]);
      end else begin
        m_cnt[i] = m_div[i] - 1;
      end
      e.pend[i] = m_pend[i];
      e.err[i]  = m_err[i];
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic sync, input logic [CH-1:0] load,
                      input logic [CH*W-1:0] div, input logic [CH*W-1:0] high);
    exp_t e;
    SYNC = sync; LOAD = load; DIV_in = div; HIGH_in = high;
    model_step(sync, load, div, high);
    @(posedge CLK_in); #1;
    LOAD = '0;
    e = sb.pop_front();
    check("clk_out",  32'(CLK_out),  32'(e.clk));
    check("tick_out", 32'(TICK_out), 32'(e.tick));
    check("pend_out", 32'(PEND_out), 32'(e.pend));
    check("err_out",  32'(ERR_out),  32'(e.err));
    hist0  = {hist0[30:0], CLK_out[0]};
    hist1  = {hist1[30:0], CLK_out[1]};
    thist0 = {thist0[30:0], TICK_out[0]};
  endtask

  task automatic run(input int n, input logic sync);
    for (int k = 0; k < n; k++) step(sync, '0, '0, '0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_clk"},  32'(CLK_out),  32'h0);
    check({tag, "_tick"}, 32'(TICK_out), 32'h0);
    check({tag, "_pend"}, 32'(PEND_out), 32'h0);
    check({tag, "_err"},  32'(ERR_out),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    RST = 1'b0; SYNC = 1'b1;
    model_reset();
    #2;
    check_zero("reset_async");
    @(posedge CLK_in); #1;
    check_zero("reset_held");
    RST = 1'b1;

    // Defaults 2/1: rise on first edge, toggle each cycle, tick every 2.
    run(4, 1'b1);
    check("default_clk0",  32'(hist0[3:0]),  32'hA);
    check("default_tick0", 32'(thist0[3:0]), 32'hA);

    // ch0 -> 5/2 loaded mid-period.
    step(1'b1, '0, '0, '0);
    step(1'b1, 2'b01, pk2(5, 0), pk2(2, 0));
    check("pend_ch0_set", 32'(PEND_out), 32'h1);
    run(10, 1'b1);
    check("ch0_5_2_clk",  32'(hist0[9:0]),  32'b1100011000);
    check("ch0_5_2_tick", 32'(thist0[9:0]), 32'b1000010000);
    check("ch1_untouched", 32'(hist1[9:0]), 32'b1010101010);

    // ch1: 7/3 then 4/1 before it applies; last legal wins.
    step(1'b1, '0, '0, '0);
    step(1'b1, 2'b10, pk2(0, 7), pk2(0, 3));
    check("pend_ch1_set", 32'(PEND_out), 32'h2);
    step(1'b1, 2'b10, pk2(0, 4), pk2(0, 1));
    check("pend_ch1_bypass", 32'(PEND_out[1]), 32'h0);
    run(8, 1'b1);
    check("ch1_4_1_clk", 32'(hist1[8:0]), 32'b100010001);

    // Illegal loads on ch0 set err and leave config alone.
    step(1'b1, 2'b01, pk2(1, 0), pk2(1, 0));
    check("err_div1", 32'(ERR_out), 32'h1);
    step(1'b1, 2'b01, pk2(6, 0), pk2(6, 0));
    check("err_high_eq_div", 32'(ERR_out), 32'h1);
    check("err_no_pend", 32'(PEND_out[0]), 32'h0);
    run(5, 1'b1);
    step(1'b1, 2'b01, pk2(6, 0), pk2(3, 0));
    check("err_cleared", 32'(ERR_out), 32'h0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(1'b1, '0, '0, '0);
      if (TICK_out[0]) found = 1'b1;
    end
    check("tick0_seen", 32'(found), 32'h1);
    run(5, 1'b1);
    check("ch0_6_3_clk", 32'(hist0[5:0]), 32'b111000);

    // ch0 3/1, ch1 8/4; SYNC hold then aligned restart.
    step(1'b1, 2'b11, pk2(3, 8), pk2(1, 4));
    run(12, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, '0, '0);
      check("hold_clk",  32'(CLK_out),  32'h0);
      check("hold_tick", 32'(TICK_out), 32'h0);
    end
    step(1'b1, '0, '0, '0);
    check("sync_rise_clk",  32'(CLK_out),  32'h3);
    check("sync_rise_tick", 32'(TICK_out), 32'h3);

    // LOAD 9/4 exactly on ch0's wrap edge.
    run(2, 1'b1);
    step(1'b1, 2'b01, pk2(9, 0), pk2(4, 0));
    check("wrap_load_pend", 32'(PEND_out), 32'h0);
    check("wrap_load_tick", 32'(TICK_out[0]), 32'h1);
    run(8, 1'b1);
    check("ch0_9_4_clk", 32'(hist0[8:0]), 32'b111100000);

    // Pending ch1 config then asynchronous reset mid-period.
    step(1'b1, 2'b10, pk2(0, 5), pk2(0, 2));
    run(1, 1'b1);
    #3 RST = 1'b0;
    #1 check_zero("reset_mid");
    model_reset();
    @(posedge CLK_in); #1;
    check_zero("reset_mid_held");
    RST = 1'b1;
    step(1'b1, '0, '0, '0);
    check("post_reset_clk",  32'(CLK_out),  32'h3);
    check("post_reset_tick", 32'(TICK_out), 32'h3);
    run(3, 1'b1);
    check("post_reset_clk0", 32'(hist0[3:0]), 32'hA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
